hazard_scoreboard: RTL and testbench

Pipeline hazard controller for the five-stage MIPS datapath. It tracks the destination register and remaining result latency (Tnew) of the instructions in E, M and W, and stalls D when an operand is not yet producible. It also generates forwarding selects for D-stage and E-stage operand reads, and sequences the multi-cycle mult/div unit's busy window. It sits beside the register file and is the only source of stall and forwarding control.

---
 rtl/hazard_scoreboard.sv | 204 ++++++++++++++++++++
 tb/tb_hazard_scoreboard.sv | 357 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: stall and forwarding control for the five-stage MIPS
// datapath. Tracks destination register and remaining result latency of the
// instructions in E, M and W, sequences the mult/div busy window, and decides
// when the instruction in D must wait or take a bypassed operand.
//
// The W slot keeps only its destination: an instruction reaching W has always
// produced its result (the largest tnew is 2, decremented twice on the way),
// so nothing downstream ever needs W's latency.
module hazard_scoreboard (
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] d_rs,
    input  logic [4:0] d_rt,
    input  logic [1:0] d_tuse_rs,
    input  logic [1:0] d_tuse_rt,
    input  logic [4:0] d_dst,
    input  logic [1:0] d_tnew,
    input  logic       d_md_start,
    input  logic       d_md_div,
    input  logic       d_md_use,
    output logic       stall,
    output logic [1:0] d_fwd_rs,
    output logic [1:0] d_fwd_rt,
    output logic [1:0] e_fwd_rs,
    output logic [1:0] e_fwd_rt,
    output logic       md_busy
);

    localparam logic [3:0] MULT_LATENCY = 4'd5;
    localparam logic [3:0] DIV_LATENCY  = 4'd10;
    localparam logic [1:0] TUSE_NONE    = 2'd3;

    localparam logic [1:0] D_FWD_RF = 2'd0;
    localparam logic [1:0] D_FWD_E  = 2'd1;
    localparam logic [1:0] D_FWD_M  = 2'd2;

    localparam logic [1:0] E_FWD_STORED = 2'd0;
    localparam logic [1:0] E_FWD_M      = 2'd2;
    localparam logic [1:0] E_FWD_W      = 2'd3;

    // E slot
    logic [4:0] e_dst_q,      e_dst_d;
    logic [1:0] e_tnew_q,     e_tnew_d;
    logic [4:0] e_rs_q,       e_rs_d;
    logic [4:0] e_rt_q,       e_rt_d;
    logic       e_md_start_q, e_md_start_d;
    logic       e_md_div_q,   e_md_div_d;

    // M slot
    logic [4:0] m_dst_q,  m_dst_d;
    logic [1:0] m_tnew_q, m_tnew_d;

    // W slot
    logic [4:0] w_dst_q, w_dst_d;

    // mult/div countdown
    logic [3:0] md_cnt_q, md_cnt_d;

    logic rs_hazard;
    logic rt_hazard;
    logic md_hazard;

    // Latency left after one more stage of progress, never going below zero.
    function automatic logic [1:0] sat_dec(input logic [1:0] t);
        return (t == 2'd0) ? 2'd0 : t - 2'd1;
    endfunction

    // A source must wait when an in-flight producer in E or M will not have
    // its result ready by the time the consumer needs it.
    function automatic logic operand_hazard(
        input logic [4:0] src,
        input logic [1:0] tuse,
        input logic [4:0] e_dst,
        input logic [1:0] e_tnew,
        input logic [4:0] m_dst,
        input logic [1:0] m_tnew
    );
        logic hit_e;
        logic hit_m;
        hit_e = (e_dst == src) && (e_tnew > tuse);
        hit_m = (m_dst == src) && (m_tnew > tuse);
        return (tuse != TUSE_NONE) && (src != 5'd0) && (hit_e || hit_m);
    endfunction

    // D-stage bypass: the youngest producer whose result already exists wins.
    function automatic logic [1:0] d_forward(
        input logic [4:0] src,
        input logic [4:0] e_dst,
        input logic [1:0] e_tnew,
        input logic [4:0] m_dst,
        input logic [1:0] m_tnew
    );
        logic [1:0] sel;
        sel = D_FWD_RF;
        if (src != 5'd0) begin
            if ((e_dst == src) && (e_tnew == 2'd0)) begin
                sel = D_FWD_E;
            end else if ((m_dst == src) && (m_tnew == 2'd0)) begin
                sel = D_FWD_M;
            end
        end
        return sel;
    endfunction

    // E-stage bypass: M has priority over W because it is the younger writer.
    function automatic logic [1:0] e_forward(
        input logic [4:0] src,
        input logic [4:0] m_dst,
        input logic [1:0] m_tnew,
        input logic [4:0] w_dst
    );
        logic [1:0] sel;
        sel = E_FWD_STORED;
        if (src != 5'd0) begin
            if ((m_dst == src) && (m_tnew == 2'd0)) begin
                sel = E_FWD_M;
            end else if (w_dst == src) begin
                sel = E_FWD_W;
            end
        end
        return sel;
    endfunction

    // Hazard detection and forwarding selects, purely from current slots and D.
    always_comb begin
        rs_hazard = operand_hazard(d_rs, d_tuse_rs, e_dst_q, e_tnew_q,
                                   m_dst_q, m_tnew_q);
        rt_hazard = operand_hazard(d_rt, d_tuse_rt, e_dst_q, e_tnew_q,
                                   m_dst_q, m_tnew_q);
        md_hazard = (d_md_use || d_md_start) &&
                    ((md_cnt_q != 4'd0) || e_md_start_q);
        stall     = rs_hazard || rt_hazard || md_hazard;

        d_fwd_rs  = d_forward(d_rs, e_dst_q, e_tnew_q, m_dst_q, m_tnew_q);
        d_fwd_rt  = d_forward(d_rt, e_dst_q, e_tnew_q, m_dst_q, m_tnew_q);
        e_fwd_rs  = e_forward(e_rs_q, m_dst_q, m_tnew_q, w_dst_q);
        e_fwd_rt  = e_forward(e_rt_q, m_dst_q, m_tnew_q, w_dst_q);

        md_busy   = (md_cnt_q != 4'd0);
    end

    // Next slot contents: everything drains one stage, and E takes either
    // the D instruction or a bubble when D is being held.
    always_comb begin
        w_dst_d  = m_dst_q;

        m_dst_d  = e_dst_q;
        m_tnew_d = sat_dec(e_tnew_q);

        if (stall) begin
            e_dst_d      = 5'd0;
            e_tnew_d     = 2'd0;
            e_rs_d       = 5'd0;
            e_rt_d       = 5'd0;
            e_md_start_d = 1'b0;
            e_md_div_d   = 1'b0;
        end else begin
            e_dst_d      = d_dst;
            e_tnew_d     = d_tnew;
            e_rs_d       = d_rs;
            e_rt_d       = d_rt;
            e_md_start_d = d_md_start;
            e_md_div_d   = d_md_start && d_md_div;
        end
    end

    // Busy window: load the unit latency as the mult/div leaves E, then count down.
    always_comb begin
        md_cnt_d = md_cnt_q;
        if (e_md_start_q) begin
            md_cnt_d = e_md_div_q ? DIV_LATENCY : MULT_LATENCY;
        end else if (md_cnt_q != 4'd0) begin
            md_cnt_d = md_cnt_q - 4'd1;
        end
    end

    // Slot and counter registers; reset empties the pipeline immediately.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            e_dst_q      <= 5'd0;
            e_tnew_q     <= 2'd0;
            e_rs_q       <= 5'd0;
            e_rt_q       <= 5'd0;
            e_md_start_q <= 1'b0;
            e_md_div_q   <= 1'b0;
            m_dst_q      <= 5'd0;
            m_tnew_q     <= 2'd0;
            w_dst_q      <= 5'd0;
            md_cnt_q     <= 4'd0;
        end else begin
            e_dst_q      <= e_dst_d;
            e_tnew_q     <= e_tnew_d;
            e_rs_q       <= e_rs_d;
            e_rt_q       <= e_rt_d;
            e_md_start_q <= e_md_start_d;
            e_md_div_q   <= e_md_div_d;
            m_dst_q      <= m_dst_d;
            m_tnew_q     <= m_tnew_d;
            w_dst_q      <= w_dst_d;
            md_cnt_q     <= md_cnt_d;
        end
    end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb_hazard_scoreboard: directed scenarios plus randomized instruction
// streams, compared every cycle against an age-based model of the pipeline.
module tb_hazard_scoreboard;

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] d_rs, d_rt, d_dst;
    logic [1:0] d_tuse_rs, d_tuse_rt, d_tnew;
    logic       d_md_start, d_md_div, d_md_use;
    logic       stall, md_busy;
    logic [1:0] d_fwd_rs, d_fwd_rt, e_fwd_rs, e_fwd_rt;

    int checks = 0;
    int errors = 0;

    // Model: instruction history by age (0 = in E, 1 = in M, 2 = in W), each
    // remembering the latency it was issued with; current latency is derived
    // from its age.
    logic [4:0] h_dst [3];
    logic [4:0] h_rs  [3];
    logic [4:0] h_rt  [3];
    logic [1:0] h_tnew[3];
    logic       h_md  [3];
    logic       h_div [3];
    int         cyc;
    int         md_start_cyc;
    int         md_lat;

    logic       exp_stall, exp_busy;
    logic [1:0] exp_dfrs, exp_dfrt, exp_efrs, exp_efrt;

    always #5 clk = ~clk;

    hazard_scoreboard dut (
        .clk        (clk),
        .reset      (reset),
        .d_rs       (d_rs),
        .d_rt       (d_rt),
        .d_tuse_rs  (d_tuse_rs),
        .d_tuse_rt  (d_tuse_rt),
        .d_dst      (d_dst),
        .d_tnew     (d_tnew),
        .d_md_start (d_md_start),
        .d_md_div   (d_md_div),
        .d_md_use   (d_md_use),
        .stall      (stall),
        .d_fwd_rs   (d_fwd_rs),
        .d_fwd_rt   (d_fwd_rt),
        .e_fwd_rs   (e_fwd_rs),
        .e_fwd_rt   (e_fwd_rt),
        .md_busy    (md_busy)
    );

    function automatic int tnew_now(int age);
        int t;
        t = int'(h_tnew[age]) - age;
        return (t > 0) ? t : 0;
    endfunction

    function automatic logic needs_wait(logic [4:0] src, logic [1:0] tuse);
        if (tuse == 2'd3 || src == 5'd0) return 1'b0;
        for (int a = 0; a < 2; a++) begin
            if (h_dst[a] == src && tnew_now(a) > int'(tuse)) return 1'b1;
        end
        return 1'b0;
    endfunction

    function automatic logic [1:0] model_dfwd(logic [4:0] src);
        if (src == 5'd0) return 2'd0;
        if (h_dst[0] == src && tnew_now(0) == 0) return 2'd1;
        if (h_dst[1] == src && tnew_now(1) == 0) return 2'd2;
        return 2'd0;
    endfunction

    function automatic logic [1:0] model_efwd(logic [4:0] src);
        if (src == 5'd0) return 2'd0;
        if (h_dst[1] == src && tnew_now(1) == 0) return 2'd2;
        if (h_dst[2] == src) return 2'd3;
        return 2'd0;
    endfunction

    task automatic model_reset();
        for (int a = 0; a < 3; a++) begin
            h_dst[a] = 5'd0; h_rs[a] = 5'd0; h_rt[a] = 5'd0;
            h_tnew[a] = 2'd0; h_md[a] = 1'b0; h_div[a] = 1'b0;
        end
        md_start_cyc = -100;
        md_lat       = 0;
    endtask

    task automatic model_eval();
        exp_busy  = (cyc > md_start_cyc) && (cyc <= md_start_cyc + md_lat);
        exp_stall = needs_wait(d_rs, d_tuse_rs) || needs_wait(d_rt, d_tuse_rt) ||
                    ((d_md_use || d_md_start) && (exp_busy || h_md[0]));
        exp_dfrs  = model_dfwd(d_rs);
        exp_dfrt  = model_dfwd(d_rt);
        exp_efrs  = model_efwd(h_rs[0]);
        exp_efrt  = model_efwd(h_rt[0]);
    endtask

    task automatic model_advance();
        if (h_md[0]) begin
            md_start_cyc = cyc;
            md_lat       = h_div[0] ? 10 : 5;
        end
        for (int a = 2; a > 0; a--) begin
            h_dst[a] = h_dst[a-1]; h_rs[a] = h_rs[a-1]; h_rt[a] = h_rt[a-1];
            h_tnew[a] = h_tnew[a-1]; h_md[a] = h_md[a-1]; h_div[a] = h_div[a-1];
        end
        if (exp_stall) begin
            h_dst[0] = 5'd0; h_rs[0] = 5'd0; h_rt[0] = 5'd0;
            h_tnew[0] = 2'd0; h_md[0] = 1'b0; h_div[0] = 1'b0;
        end else begin
            h_dst[0] = d_dst; h_rs[0] = d_rs; h_rt[0] = d_rt;
            h_tnew[0] = d_tnew; h_md[0] = d_md_start; h_div[0] = d_md_start && d_md_div;
        end
        cyc++;
    endtask

    task automatic check_val(string name, logic [3:0] act, logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
        end
    endtask

    task automatic check_output();
        model_eval();
        check_val("stall",    {3'd0, stall},   {3'd0, exp_stall});
        check_val("md_busy",  {3'd0, md_busy}, {3'd0, exp_busy});
        check_val("d_fwd_rs", {2'd0, d_fwd_rs}, {2'd0, exp_dfrs});
        check_val("d_fwd_rt", {2'd0, d_fwd_rt}, {2'd0, exp_dfrt});
        check_val("e_fwd_rs", {2'd0, e_fwd_rs}, {2'd0, exp_efrs});
        check_val("e_fwd_rt", {2'd0, e_fwd_rt}, {2'd0, exp_efrt});
    endtask

    task automatic check_all_zero(string tag);
        check_val({tag, " stall"},    {3'd0, stall},    4'd0);
        check_val({tag, " md_busy"},  {3'd0, md_busy},  4'd0);
        check_val({tag, " d_fwd_rs"}, {2'd0, d_fwd_rs}, 4'd0);
        check_val({tag, " d_fwd_rt"}, {2'd0, d_fwd_rt}, 4'd0);
        check_val({tag, " e_fwd_rs"}, {2'd0, e_fwd_rs}, 4'd0);
        check_val({tag, " e_fwd_rt"}, {2'd0, e_fwd_rt}, 4'd0);
    endtask

    task automatic apply_stimulus(logic [4:0] rs, logic [4:0] rt, logic [1:0] tuse_rs,
                                  logic [1:0] tuse_rt, logic [4:0] dst, logic [1:0] tnew,
                                  logic md_start, logic md_div, logic md_use);
        d_rs = rs; d_rt = rt; d_tuse_rs = tuse_rs; d_tuse_rt = tuse_rt;
        d_dst = dst; d_tnew = tnew;
        d_md_start = md_start; d_md_div = md_div; d_md_use = md_use;
    endtask

    task automatic idle();
        apply_stimulus(5'd0, 5'd0, 2'd3, 2'd3, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0);
    endtask

    // Outputs settle, then are compared against the model.
    task automatic eval_now();
        #1;
        check_output();
    endtask

    // Cross one rising edge and move the model with it.
    task automatic clock();
        @(posedge clk);
        model_advance();
        #1;
    endtask

    task automatic drain();
        idle();
        for (int i = 0; i < 12; i++) begin
            eval_now();
            clock();
        end
    endtask

    initial begin
        int stall_cycles;
        int busy_cycles;
        logic [4:0] r_rs, r_rt, r_dst;
        logic [1:0] r_trs, r_trt, r_tnew;
        logic r_mds, r_mdd, r_mdu;

        cyc = 0;
        model_reset();
        reset = 1'b0;
        idle();
        @(posedge clk);
        #1;
        check_all_zero("reset");
        reset = 1'b1;
        #1;

        // Case 1: ALU producer followed by ALU consumer.
        apply_stimulus(5'd1, 5'd2, 2'd1, 2'd1, 5'd3, 2'd1, 1'b0, 1'b0, 1'b0);
        eval_now();
        check_val("alu prod stall", {3'd0, stall}, 4'd0);
        clock();
        apply_stimulus(5'd3, 5'd4, 2'd1, 2'd1, 5'd6, 2'd1, 1'b0, 1'b0, 1'b0);
        eval_now();
        check_val("alu cons stall", {3'd0, stall}, 4'd0);
        clock();
        idle();
        eval_now();
        check_val("alu e_fwd_rs", {2'd0, e_fwd_rs}, 4'd2);
        clock();
        drain();

        // Case 2: load followed by a branch on the loaded register.
        apply_stimulus(5'd1, 5'd0, 2'd1, 2'd3, 5'd5, 2'd2, 1'b0, 1'b0, 1'b0);
        eval_now();
        clock();
        apply_stimulus(5'd5, 5'd0, 2'd0, 2'd3, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0);
        eval_now();
        check_val("lw-beq stall1", {3'd0, stall}, 4'd1);
        clock();
        eval_now();
        check_val("lw-beq stall2", {3'd0, stall}, 4'd1);
        clock();
        eval_now();
        check_val("lw-beq release", {3'd0, stall}, 4'd0);
        check_val("lw-beq d_fwd_rs", {2'd0, d_fwd_rs}, 4'd0);
        clock();
        drain();

        // Load followed by an ALU use: exactly one bubble.
        apply_stimulus(5'd1, 5'd0, 2'd1, 2'd3, 5'd7, 2'd2, 1'b0, 1'b0, 1'b0);
        eval_now();
        clock();
        apply_stimulus(5'd7, 5'd0, 2'd1, 2'd3, 5'd8, 2'd1, 1'b0, 1'b0, 1'b0);
        eval_now();
        check_val("lw-add stall1", {3'd0, stall}, 4'd1);
        clock();
        eval_now();
        check_val("lw-add release", {3'd0, stall}, 4'd0);
        clock();
        drain();

        // Case 3: jal then jr $31.
        apply_stimulus(5'd0, 5'd0, 2'd3, 2'd3, 5'd31, 2'd0, 1'b0, 1'b0, 1'b0);
        eval_now();
        clock();
        apply_stimulus(5'd31, 5'd0, 2'd0, 2'd3, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0);
        eval_now();
        check_val("jr stall", {3'd0, stall}, 4'd0);
        check_val("jr d_fwd_rs", {2'd0, d_fwd_rs}, 4'd1);
        clock();
        drain();

        // Case 4: div then mfhi.
        apply_stimulus(5'd8, 5'd9, 2'd1, 2'd1, 5'd0, 2'd0, 1'b1, 1'b1, 1'b0);
        eval_now();
        clock();
        apply_stimulus(5'd0, 5'd0, 2'd3, 2'd3, 5'd10, 2'd1, 1'b0, 1'b0, 1'b1);
        stall_cycles = 0;
        busy_cycles  = 0;
        for (int i = 0; i < 20; i++) begin
            eval_now();
            if (md_busy) busy_cycles++;
            if (!stall) break;
            stall_cycles++;
            clock();
        end
        check_val("div-mfhi stall cycles", 4'(stall_cycles), 4'd11);
        check_val("div busy cycles", 4'(busy_cycles), 4'd10);
        clock();
        drain();

        // mult busy window is five cycles.
        apply_stimulus(5'd8, 5'd9, 2'd1, 2'd1, 5'd0, 2'd0, 1'b1, 1'b0, 1'b0);
        busy_cycles = 0;
        for (int i = 0; i < 9; i++) begin
            eval_now();
            if (md_busy) busy_cycles++;
            clock();
            idle();
        end
        check_val("mult busy cycles", 4'(busy_cycles), 4'd5);
        drain();

        // Case 5: register 0 never hazards or forwards.
        apply_stimulus(5'd1, 5'd0, 2'd1, 2'd3, 5'd0, 2'd2, 1'b0, 1'b0, 1'b0);
        eval_now();
        clock();
        apply_stimulus(5'd0, 5'd0, 2'd0, 2'd0, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0);
        eval_now();
        check_val("r0 stall", {3'd0, stall}, 4'd0);
        check_val("r0 d_fwd_rs", {2'd0, d_fwd_rs}, 4'd0);
        clock();
        drain();

        // Case 6a: reset during a load-use stall.
        apply_stimulus(5'd1, 5'd0, 2'd1, 2'd3, 5'd5, 2'd2, 1'b0, 1'b0, 1'b0);
        eval_now();
        clock();
        apply_stimulus(5'd5, 5'd0, 2'd0, 2'd3, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0);
        eval_now();
        check_val("pre-reset stall", {3'd0, stall}, 4'd1);
        reset = 1'b0;
        #1;
        check_all_zero("async reset lw");
        model_reset();
        @(posedge clk);
        #2;
        reset = 1'b1;
        idle();
        eval_now();
        clock();

        // Case 6b: reset during a div.
        apply_stimulus(5'd8, 5'd9, 2'd1, 2'd1, 5'd0, 2'd0, 1'b1, 1'b1, 1'b0);
        eval_now();
        clock();
        idle();
        eval_now();
        clock();
        eval_now();
        check_val("pre-reset busy", {3'd0, md_busy}, 4'd1);
        reset = 1'b0;
        #1;
        check_all_zero("async reset div");
        model_reset();
        @(posedge clk);
        #2;
        reset = 1'b1;
        eval_now();
        clock();

        // Randomized streams; a stalled instruction is held in D like a real pipeline.
        r_rs = 0; r_rt = 0; r_dst = 0; r_trs = 3; r_trt = 3; r_tnew = 0;
        r_mds = 0; r_mdd = 0; r_mdu = 0;
        exp_stall = 1'b0;
        for (int i = 0; i < 1500; i++) begin
            if (!exp_stall) begin
                r_rs   = 5'($urandom_range(0, 3));
                r_rt   = 5'($urandom_range(0, 3));
                r_trs  = 2'($urandom_range(0, 3));
                r_trt  = 2'($urandom_range(0, 3));
                r_dst  = 5'($urandom_range(0, 3));
                r_tnew = 2'($urandom_range(0, 2));
                r_mds  = ($urandom_range(0, 11) == 0);
                r_mdd  = 1'($urandom_range(0, 1));
                r_mdu  = !r_mds && ($urandom_range(0, 9) == 0);
            end
            apply_stimulus(r_rs, r_rt, r_trs, r_trt, r_dst, r_tnew, r_mds, r_mdd, r_mdu);
            eval_now();
            clock();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
